// File: rtl/chiplet_types_pkg.sv
// Shared types for the chiplet link: flit and phit containers, link TX FSM
// states and a small sizing helper.
package chiplet_types_pkg;

    localparam int FLIT_W = 32;
    localparam int PHIT_W = 8;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [PHIT_W-1:0] phit_t;

    typedef enum logic {
        LINK_TX_IDLE = 1'b0,
        LINK_TX_SEND = 1'b1
    } link_tx_state_t;

    // Number of b-wide slices needed to cover a bits.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/link_tx_fifo.sv
// Small synchronous FIFO with registered occupancy. Pushes into a full FIFO
// and pops from an empty FIFO are ignored. Head data is read combinationally.
module link_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // Status comes from the registered count only, so full never depends on pop.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks push - pop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/switch_link_tx.sv
// Egress stage behind a switch output port: buffers whole flits, serializes
// them LSB-slice first onto a narrow link, and converts link credit returns
// into per-VC credit_granted pulses for the switch.
//
// Link handshake: phit_out/phit_last are meaningful while phit_valid is high;
// a phit transfers on a clock edge where phit_valid && phit_ready, and until
// then phit_valid, phit_out and phit_last hold steady.
module switch_link_tx
    import chiplet_types_pkg::*;
#(
    parameter int NUM_VCS    = 2,
    parameter int PHIT_WIDTH = 8,
    parameter int FLIT_WIDTH = $bits(flit_t),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  flit_t                        in_flit,
    input  logic                         data_ready_in,
    output logic                         packet_sent,
    output logic [NUM_VCS-1:0]           credit_granted,
    output logic [PHIT_WIDTH-1:0]        phit_out,
    output logic                         phit_valid,
    output logic                         phit_last,
    input  logic                         phit_ready,
    input  logic                         credit_return_valid,
    input  logic [$clog2(NUM_VCS)-1:0]   credit_return_vc,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output link_tx_state_t               tx_state
);

    localparam int BEATS   = ceil_div(FLIT_WIDTH, PHIT_WIDTH);
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SHIFT_W = BEATS * PHIT_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    link_tx_state_t         state, state_next;
    logic [SHIFT_W-1:0]     shreg, shreg_next;
    logic [BEAT_W-1:0]      beat, beat_next;
    logic [FLIT_WIDTH-1:0]  fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    // The switch holds in_flit until it sees this, so one accept per flit.
    assign packet_sent = data_ready_in && !fifo_full;
    assign tx_state    = state;

    link_tx_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (packet_sent),
        .pop   (fifo_pop),
        .wdata (in_flit),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Serializer state, shift register and beat counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= LINK_TX_IDLE;
            shreg <= '0;
            beat  <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            beat  <= beat_next;
        end
    end

    // Next-state and link outputs; the head flit is zero-extended so the
    // final beat is padded above FLIT_WIDTH.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        beat_next  = beat;
        fifo_pop   = 1'b0;
        phit_valid = 1'b0;
        phit_last  = 1'b0;
        phit_out   = '0;
        case (state)
            LINK_TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shreg_next = SHIFT_W'(fifo_head);
                    beat_next  = '0;
                    state_next = LINK_TX_SEND;
                end
            end
            LINK_TX_SEND: begin
                phit_valid = 1'b1;
                phit_out   = shreg[PHIT_WIDTH-1:0];
                phit_last  = (beat == LAST_BEAT);
                if (phit_ready) begin
                    if (phit_last) begin
                        if (!fifo_empty) begin
                            // Back-to-back flits: reload without an idle bubble.
                            fifo_pop   = 1'b1;
                            shreg_next = SHIFT_W'(fifo_head);
                            beat_next  = '0;
                        end else begin
                            state_next = LINK_TX_IDLE;
                        end
                    end else begin
                        shreg_next = shreg >> PHIT_WIDTH;
                        beat_next  = beat + BEAT_W'(1);
                    end
                end
            end
            default: state_next = LINK_TX_IDLE;
        endcase
    end

    // One registered pulse per credit return; out-of-range VCs match no bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            credit_granted <= '0;
        end else begin
            for (int i = 0; i < NUM_VCS; i++) begin
                credit_granted[i] <= credit_return_valid && (int'(credit_return_vc) == i);
            end
        end
    end

endmodule

// File: tb/tb_switch_link_tx.sv
// Bench for switch_link_tx: flits are serialized into an expected-phit queue
// when accepted and compared as the link takes each phit.
module tb_switch_link_tx;
  import chiplet_types_pkg::*;

  localparam int PW    = 8;
  localparam int BEATS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (NUM_VCS = 2) ----------------
  flit_t          in_flit;
  logic           data_ready_in;
  logic           packet_sent;
  logic [1:0]     credit_granted;
  logic [PW-1:0]  phit_out;
  logic           phit_valid;
  logic           phit_last;
  logic           phit_ready;
  logic           cr_valid;
  logic [0:0]     cr_vc;
  logic [2:0]     fifo_count;
  link_tx_state_t tx_state;

  switch_link_tx u_dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .in_flit             (in_flit),
    .data_ready_in       (data_ready_in),
    .packet_sent         (packet_sent),
    .credit_granted      (credit_granted),
    .phit_out            (phit_out),
    .phit_valid          (phit_valid),
    .phit_last           (phit_last),
    .phit_ready          (phit_ready),
    .credit_return_valid (cr_valid),
    .credit_return_vc    (cr_vc),
    .fifo_count          (fifo_count),
    .tx_state            (tx_state)
  );

  // ---------------- second build (NUM_VCS = 3) for out-of-range VCs ----------------
  logic           d3_packet_sent;
  logic [2:0]     d3_credit_granted;
  logic [PW-1:0]  d3_phit_out;
  logic           d3_phit_valid;
  logic           d3_phit_last;
  logic           d3_cr_valid;
  logic [1:0]     d3_cr_vc;
  logic [2:0]     d3_fifo_count;
  link_tx_state_t d3_tx_state;

  switch_link_tx #(.NUM_VCS(3)) u_dut3 (
    .clk                 (clk),
    .n_rst               (n_rst),
    .in_flit             ('0),
    .data_ready_in       (1'b0),
    .packet_sent         (d3_packet_sent),
    .credit_granted      (d3_credit_granted),
    .phit_out            (d3_phit_out),
    .phit_valid          (d3_phit_valid),
    .phit_last           (d3_phit_last),
    .phit_ready          (1'b1),
    .credit_return_valid (d3_cr_valid),
    .credit_return_vc    (d3_cr_vc),
    .fifo_count          (d3_fifo_count),
    .tx_state            (d3_tx_state)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  int sent_cnt = 0;
  logic [PW:0] exp_q[$];   // {last, data}
  logic [PW:0] exp_phit;

  always @(negedge clk) begin
    if (n_rst) begin
      if (packet_sent) begin
        sent_cnt++;
        for (int b = 0; b < BEATS; b++) begin
          exp_q.push_back({(b == BEATS-1), in_flit[b*PW +: PW]});
        end
      end
      if (phit_valid && phit_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL phit_extra: got data=%h last=%b, required no phit", phit_out, phit_last);
        end else begin
          exp_phit = exp_q.pop_front();
          if ({phit_last, phit_out} !== exp_phit) begin
            miscompares++;
            $display("FAIL phit_data: got data=%h last=%b, required data=%h last=%b",
                     phit_out, phit_last, exp_phit[PW-1:0], exp_phit[PW]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks (enter and leave just after posedge) ----------------
  task automatic send_flit(input logic [31:0] f);
    bit got;
    got = 1'b0;
    in_flit = f;
    data_ready_in = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (packet_sent) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL accept_timeout: got no packet_sent for %h, required one", f);
    end
    @(posedge clk); #1;
    data_ready_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d phits pending, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    bit v;
    v = 1'b0;
    for (int i = 0; i < 20 && !v; i++) begin
      @(negedge clk);
      v = phit_valid;
    end
    vectors++;
    if (!v) begin
      miscompares++;
      $display("FAIL %s_valid_timeout: got phit_valid=0, required 1", tag);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({phit_valid, phit_last, phit_out, packet_sent} !== '0) begin
      miscompares++;
      $display("FAIL reset_link: got valid=%b last=%b data=%h sent=%b, required all 0",
               phit_valid, phit_last, phit_out, packet_sent);
    end
    vectors++;
    if (credit_granted !== 2'b00 || d3_credit_granted !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_credit: got %b/%b, required 00/000", credit_granted, d3_credit_granted);
    end
    vectors++;
    if (fifo_count !== 3'd0 || tx_state !== LINK_TX_IDLE) begin
      miscompares++;
      $display("FAIL reset_fifo: got count=%0d state=%0d, required 0/IDLE", fifo_count, tx_state);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  task automatic test_single();
    int s0;
    s0 = sent_cnt;
    phit_ready = 1'b1;
    send_flit(32'hDEADBEEF);
    wait_drain();
    @(negedge clk);
    vectors++;
    if (phit_valid !== 1'b0 || tx_state !== LINK_TX_IDLE) begin
      miscompares++;
      $display("FAIL single_idle: got valid=%b state=%0d, required 0/IDLE", phit_valid, tx_state);
    end
    vectors++;
    if (sent_cnt - s0 != 1) begin
      miscompares++;
      $display("FAIL single_sent: got %0d accepts, required 1", sent_cnt - s0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    phit_ready = 1'b0;
    send_flit(32'hDEADBEEF);
    wait_valid("stall");
    @(posedge clk); #1;
    phit_ready = 1'b1;          // beat 0 transfers on the next edge
    @(posedge clk); #1;
    phit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (phit_valid !== 1'b1 || phit_out !== 8'hBE || phit_last !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: cycle %0d got valid=%b data=%h last=%b, required 1/be/0",
                 i, phit_valid, phit_out, phit_last);
      end
    end
    @(posedge clk); #1;
    phit_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_fill();
    logic [31:0] f[6];
    int s0;
    int bubbles;
    int stalls;
    s0 = sent_cnt;
    bubbles = 0;
    stalls = 0;
    for (int i = 0; i < 6; i++) f[i] = $urandom;
    phit_ready = 1'b0;
    // One flit moves into the serializer, four fill the FIFO.
    for (int i = 0; i < 5; i++) send_flit(f[i]);
    in_flit = f[5];
    data_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (packet_sent !== 1'b0) stalls++;
    end
    vectors++;
    if (stalls != 0) begin
      miscompares++;
      $display("FAIL fill_full_accept: got %0d accepts while full, required 0", stalls);
    end
    vectors++;
    if (fifo_count !== 3'd4) begin
      miscompares++;
      $display("FAIL fill_count: got %0d, required 4", fifo_count);
    end
    @(posedge clk); #1;
    phit_ready = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (!phit_valid) bubbles++;
        if (packet_sent) got = 1'b1;
      end
      @(posedge clk); #1;
      data_ready_in = 1'b0;
    end
    vectors++;
    if (sent_cnt - s0 != 6) begin
      miscompares++;
      $display("FAIL fill_sent: got %0d accepts, required 6", sent_cnt - s0);
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (!phit_valid && exp_q.size() != 0) bubbles++;
    end
    vectors++;
    if (bubbles != 0) begin
      miscompares++;
      $display("FAIL fill_bubble: got %0d idle cycles, required 0", bubbles);
    end
    wait_drain();
  endtask

  task automatic test_credit();
    logic [1:0] exp2[4];
    logic [0:0] vcs[3];
    exp2[0] = 2'b10; exp2[1] = 2'b01; exp2[2] = 2'b10; exp2[3] = 2'b00;
    vcs[0] = 1'b1; vcs[1] = 1'b0; vcs[2] = 1'b1;
    cr_valid = 1'b1;
    cr_vc = vcs[0];
    @(negedge clk);
    vectors++;
    if (credit_granted !== 2'b00) begin
      miscompares++;
      $display("FAIL credit_early: got %b, required 00", credit_granted);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 2) cr_vc = vcs[i+1];
      else cr_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (credit_granted !== exp2[i]) begin
        miscompares++;
        $display("FAIL credit_seq%0d: got %b, required %b", i, credit_granted, exp2[i]);
      end
    end
    // Three-VC build: VC 2 is real, VC 3 is out of range.
    @(posedge clk); #1;
    d3_cr_valid = 1'b1;
    d3_cr_vc = 2'd2;
    @(posedge clk); #1;
    d3_cr_vc = 2'd3;
    @(negedge clk);
    vectors++;
    if (d3_credit_granted !== 3'b100) begin
      miscompares++;
      $display("FAIL credit_vc2: got %b, required 100", d3_credit_granted);
    end
    @(posedge clk); #1;
    d3_cr_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (d3_credit_granted !== 3'b000) begin
      miscompares++;
      $display("FAIL credit_vc3: got %b, required 000", d3_credit_granted);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_push_pop();
    phit_ready = 1'b0;
    send_flit(32'h0A0B0C0D);
    send_flit(32'h11223344);
    send_flit(32'h55667788);
    @(negedge clk);
    vectors++;
    if (fifo_count !== 3'd2) begin
      miscompares++;
      $display("FAIL pp_setup_count: got %0d, required 2", fifo_count);
    end
    @(posedge clk); #1;
    phit_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    phit_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (phit_last !== 1'b1 || phit_out !== 8'h0A) begin
      miscompares++;
      $display("FAIL pp_last_beat: got last=%b data=%h, required 1/0a", phit_last, phit_out);
    end
    @(posedge clk); #1;
    phit_ready = 1'b1;
    in_flit = 32'h99AABBCC;
    data_ready_in = 1'b1;
    @(negedge clk);
    vectors++;
    if (packet_sent !== 1'b1) begin
      miscompares++;
      $display("FAIL pp_accept: got packet_sent=%b, required 1", packet_sent);
    end
    @(posedge clk); #1;
    phit_ready = 1'b0;
    data_ready_in = 1'b0;
    @(negedge clk);
    vectors++;
    if (fifo_count !== 3'd2) begin
      miscompares++;
      $display("FAIL pp_count: got %0d, required 2", fifo_count);
    end
    @(posedge clk); #1;
    phit_ready = 1'b1;
    wait_drain();
    // Nine flits take both pointers around the ring at least twice.
    for (int i = 0; i < 9; i++) send_flit($urandom);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    phit_ready = 1'b0;
    send_flit(32'hA5C30F96);
    send_flit(32'h0BADF00D);
    wait_valid("rst");
    @(posedge clk); #1;
    phit_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    phit_ready = 1'b0;           // now holding beat 2
    cr_valid = 1'b1;
    cr_vc = 1'b1;
    @(posedge clk); #1;
    cr_valid = 1'b0;
    vectors++;
    if (phit_valid !== 1'b1 || phit_out !== 8'hC3 || credit_granted !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_pre: got valid=%b data=%h credit=%b, required 1/c3/10",
               phit_valid, phit_out, credit_granted);
    end
    #2;
    n_rst = 1'b0;
    #1;
    vectors++;
    if ({phit_valid, phit_last, phit_out} !== '0 || credit_granted !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_async_out: got valid=%b last=%b data=%h credit=%b, required all 0",
               phit_valid, phit_last, phit_out, credit_granted);
    end
    vectors++;
    if (fifo_count !== 3'd0 || tx_state !== LINK_TX_IDLE) begin
      miscompares++;
      $display("FAIL rst_async_fifo: got count=%0d state=%0d, required 0/IDLE", fifo_count, tx_state);
    end
    exp_q.delete();
    @(posedge clk); #1;
    n_rst = 1'b1;
    phit_ready = 1'b1;
    send_flit(32'h12345678);
    wait_drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    in_flit = '0;
    data_ready_in = 1'b0;
    phit_ready = 1'b0;
    cr_valid = 1'b0;
    cr_vc = '0;
    d3_cr_valid = 1'b0;
    d3_cr_vc = '0;
    test_reset();
    test_single();
    test_stall();
    test_fill();
    test_credit();
    test_push_pop();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d phits pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
